// File: rtl/dbg_pkg.sv
// Shared types and constants for the Mock8080 debug clock controller.
// Mode encoding matches the 2-bit mode output seen by the LCD driver.
package dbg_pkg;

   typedef enum logic [1:0] {
      MODE_HALT  = 2'b00,
      MODE_RUN   = 2'b01,
      MODE_STEP  = 2'b10,
      MODE_BREAK = 2'b11
   } mode_t;

   localparam int unsigned MIN_PERIOD = 2;

endpackage

// File: rtl/dbg_wrap_counter.sv
// Up/down counter that wraps between 0 and NUM_REGS-1; simultaneous inc and dec cancel.
// Used as the debug-register selector for the LCD debug view.
module dbg_wrap_counter #(
   parameter int SEL_W    = 4,
   parameter int NUM_REGS = 12
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             inc,
   input  logic             dec,
   output logic [SEL_W-1:0] count
);

   localparam logic [SEL_W-1:0] LAST = SEL_W'(NUM_REGS - 1);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= '0;
      end else if (inc && !dec) begin
         count <= (count == LAST) ? '0 : count + SEL_W'(1);
      end else if (dec && !inc) begin
         count <= (count == '0) ? LAST : count - SEL_W'(1);
      end
   end

endmodule

// File: rtl/dbg_clock_controller.sv
// Debug clock/step controller: programmable-period CPU tick and clock with run/halt/step modes.
// Optional breakpoint halt enabled by defining DBG_BREAKPOINT_EN.
//
//  state      | meaning
//  MODE_HALT  | cnt held at 0, no ticks, waiting for run_toggle / step_req
//  MODE_RUN   | free-running ticks every period_q cycles
//  MODE_STEP  | one tick after period_q cycles, then HALT (or RUN if toggled meanwhile)
//  MODE_BREAK | breakpoint hit; behaves like HALT, next tick exempt from the compare
module dbg_clock_controller
   import dbg_pkg::*;
#(
   parameter int PERIOD_W       = 29,
   parameter int DEFAULT_PERIOD = 100000000,
   parameter int NUM_REGS       = 12,
   parameter int SEL_W          = 4,
   parameter int ADDR_W         = 8
) (
   input  logic                qzt_clk,
   input  logic                reset_n,
   input  logic                run_toggle,
   input  logic                step_req,
   input  logic [PERIOD_W-1:0] period_in,
   input  logic                reg_next,
   input  logic                reg_prev,
   input  logic [ADDR_W-1:0]   cpu_addr,
   input  logic [ADDR_W-1:0]   bp_addr,
   input  logic                bp_en,
   output logic                cpu_tick,
   output logic                cpu_clk,
   output logic [1:0]          mode,
   output logic [SEL_W-1:0]    reg_sel
);

   localparam logic [PERIOD_W-1:0] DEF_P = PERIOD_W'(DEFAULT_PERIOD);
   localparam logic [PERIOD_W-1:0] MIN_P = PERIOD_W'(MIN_PERIOD);

   mode_t               mode_q, mode_d;
   logic [PERIOD_W-1:0] cnt_q, cnt_d;
   logic [PERIOD_W-1:0] period_q, period_d;
   logic [PERIOD_W-1:0] period_req;
   logic                tick_q, tick_d;
   logic                clk_q, clk_d;
   logic                pend_q, pend_d;
   logic                exempt_q, exempt_d;
   logic                wrap;
   logic                bp_hit;

   assign period_req = (period_in < MIN_P) ? MIN_P : period_in;
   assign wrap       = (cnt_q == period_q - PERIOD_W'(1));

`ifdef DBG_BREAKPOINT_EN
   assign bp_hit = bp_en && (cpu_addr == bp_addr) && !exempt_q;
`else
   logic bp_unused;
   assign bp_hit    = 1'b0;
   assign bp_unused = ^{bp_en, cpu_addr, bp_addr, exempt_q};
`endif

   always_ff @(posedge qzt_clk or negedge reset_n) begin
      if (!reset_n) begin
         mode_q   <= MODE_HALT;
         cnt_q    <= '0;
         period_q <= DEF_P;
         tick_q   <= 1'b0;
         clk_q    <= 1'b0;
         pend_q   <= 1'b0;
         exempt_q <= 1'b0;
      end else begin
         mode_q   <= mode_d;
         cnt_q    <= cnt_d;
         period_q <= period_d;
         tick_q   <= tick_d;
         clk_q    <= clk_d;
         pend_q   <= pend_d;
         exempt_q <= exempt_d;
      end
   end

   always_comb begin
      mode_d   = mode_q;
      cnt_d    = cnt_q;
      period_d = period_q;
      tick_d   = 1'b0;
      pend_d   = pend_q;
      exempt_d = exempt_q;

      unique case (mode_q)
         MODE_HALT, MODE_BREAK: begin
            cnt_d = '0;
            if (run_toggle || step_req) begin
               mode_d   = run_toggle ? MODE_RUN : MODE_STEP;
               period_d = period_req;
               pend_d   = 1'b0;
               if (mode_q == MODE_BREAK) exempt_d = 1'b1;
            end
         end
         MODE_RUN: begin
            if (run_toggle) begin
               mode_d = MODE_HALT;
               cnt_d  = '0;
            end else if (wrap) begin
               cnt_d = '0;
               if (bp_hit) begin
                  mode_d = MODE_BREAK;
               end else begin
                  tick_d   = 1'b1;
                  period_d = period_req;
                  exempt_d = 1'b0;
               end
            end else begin
               cnt_d = cnt_q + PERIOD_W'(1);
            end
         end
         MODE_STEP: begin
            // a toggle seen mid-step is remembered and applied once the step tick goes out
            pend_d = pend_q | run_toggle;
            if (wrap) begin
               cnt_d    = '0;
               tick_d   = 1'b1;
               period_d = period_req;
               exempt_d = 1'b0;
               pend_d   = 1'b0;
               mode_d   = (pend_q || run_toggle) ? MODE_RUN : MODE_HALT;
            end else begin
               cnt_d = cnt_q + PERIOD_W'(1);
            end
         end
         default: ;
      endcase

      clk_d = clk_q;
      if (tick_q) begin
         clk_d = 1'b1;
      end else if (mode_q == MODE_HALT || mode_q == MODE_BREAK || cnt_q == (period_q >> 1)) begin
         clk_d = 1'b0;
      end
   end

   dbg_wrap_counter #(
      .SEL_W    (SEL_W),
      .NUM_REGS (NUM_REGS)
   ) u_reg_sel (
      .clk   (qzt_clk),
      .rst_n (reset_n),
      .inc   (reg_next),
      .dec   (reg_prev),
      .count (reg_sel)
   );

   assign cpu_tick = tick_q;
   assign cpu_clk  = clk_q;
   assign mode     = mode_q;

endmodule
